// File: rtl/debug_cmd_if.sv
// Command/response and bus signals between the JTAG-side debug command
// engine (master) and its environment: the JTAG register and the system bus (slave).
interface debug_cmd_if;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic [31:0] resp_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        halt_req;
  logic        busy;
  logic        err;

  modport master (
    input  cmd_word, cmd_valid, bus_ack, bus_rdata,
    output resp_data, bus_req, bus_we, bus_addr, bus_wdata, halt_req, busy, err
  );

  modport slave (
    output cmd_word, cmd_valid, bus_ack, bus_rdata,
    input  resp_data, bus_req, bus_we, bus_addr, bus_wdata, halt_req, busy, err
  );
endinterface

// File: rtl/debug_cmd_engine.sv
// Debug command engine: decodes JTAG command words into halt control and
// single bus read/write transactions with an auto-incrementing address and timeout.
module debug_cmd_engine #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic        clk,
  input logic        reset,
  debug_cmd_if.master dbg
);

  typedef enum logic [1:0] {IDLE, ARG, REQ} state_t;
  typedef enum logic [1:0] {
    OP_CTRL     = 2'b00,
    OP_SET_ADDR = 2'b01,
    OP_WRITE    = 2'b10,
    OP_READ     = 2'b11
  } op_t;

  // The counter only needs to reach TIMEOUT_CYCLES-1: the request drops on that edge.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             arg_is_write;
  logic [CNT_W-1:0] to_cnt;
  op_t              op;

  assign op       = op_t'(dbg.cmd_word[31:30]);
  assign dbg.busy = (state != IDLE);

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      arg_is_write  <= 1'b0;
      to_cnt        <= '0;
      dbg.bus_req   <= 1'b0;
      dbg.bus_we    <= 1'b0;
      dbg.bus_addr  <= '0;
      dbg.bus_wdata <= '0;
      dbg.resp_data <= '0;
      dbg.halt_req  <= 1'b0;
      dbg.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dbg.cmd_valid) begin
            case (op)
              OP_CTRL: begin
                dbg.halt_req <= dbg.cmd_word[0];
                if (dbg.cmd_word[1]) dbg.err <= 1'b0;
              end
              OP_SET_ADDR: begin
                state        <= ARG;
                arg_is_write <= 1'b0;
              end
              OP_WRITE: begin
                state        <= ARG;
                arg_is_write <= 1'b1;
              end
              OP_READ: begin
                state       <= REQ;
                dbg.bus_req <= 1'b1;
                dbg.bus_we  <= 1'b0;
                to_cnt      <= '0;
              end
            endcase
          end
        end

        // Any word arriving here is the argument, regardless of its op bits.
        ARG: begin
          if (dbg.cmd_valid) begin
            if (arg_is_write) begin
              dbg.bus_wdata <= dbg.cmd_word;
              state         <= REQ;
              dbg.bus_req   <= 1'b1;
              dbg.bus_we    <= 1'b1;
              to_cnt        <= '0;
            end else begin
              dbg.bus_addr <= dbg.cmd_word;
              state        <= IDLE;
            end
          end
        end

        REQ: begin
          if (dbg.cmd_valid) dbg.err <= 1'b1;
          // Ack takes priority over a timeout expiring on the same edge.
          if (dbg.bus_ack) begin
            dbg.bus_req  <= 1'b0;
            state        <= IDLE;
            dbg.bus_addr <= dbg.bus_addr + 32'd4;
            if (!dbg.bus_we) dbg.resp_data <= dbg.bus_rdata;
          end else if (to_cnt == CNT_LAST) begin
            dbg.bus_req <= 1'b0;
            dbg.err     <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_cmd_engine.sv
// Self-checking bench for debug_cmd_engine: directed scenarios plus randomized
// commands checked against a transaction-level model of address, response, err and halt.
module tb_debug_cmd_engine;

  localparam int TO = 20;

  logic clk;
  logic reset;

  debug_cmd_if ifc ();

  debug_cmd_engine #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, at the level of the programmer-visible effects.
  logic [31:0] m_addr = '0;
  logic [31:0] m_resp = '0;
  bit          m_err  = 1'b0;
  bit          m_halt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    ifc.cmd_word  = w;
    ifc.cmd_valid = 1'b1;
    tick();
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(ifc.busy),     32'(0));
    check({tag, "_req"},     32'(ifc.bus_req),  32'(0));
    check({tag, "_err"},     32'(ifc.err),      32'(m_err));
    check({tag, "_halt"},    32'(ifc.halt_req), 32'(m_halt));
    check({tag, "_resp"},    ifc.resp_data,     m_resp);
    check({tag, "_addr"},    ifc.bus_addr,      m_addr);
  endtask

  task automatic ctrl(input logic [29:0] low);
    send_word({2'b00, low});
    m_halt = low[0];
    if (low[1]) m_err = 1'b0;
    check_idle("ctrl");
  endtask

  task automatic set_addr(input logic [29:0] low, input logic [31:0] a);
    send_word({2'b01, low});
    check("setaddr_busy", 32'(ifc.busy), 32'(1));
    check("setaddr_noreq", 32'(ifc.bus_req), 32'(0));
    send_word(a);
    m_addr = a;
    check_idle("setaddr");
  endtask

  // d < TO: ack pulsed in REQ cycle d; d >= TO: never acked.
  // ovr_at >= 0: a stray command word is pulsed in REQ cycle ovr_at.
  task automatic run_xfer(input bit is_write, input logic [29:0] low, input logic [31:0] wdata,
                          input int d, input logic [31:0] rdata, input int ovr_at);
    int ncyc;
    logic [31:0] addr_exp;
    addr_exp = m_addr;
    if (is_write) begin
      send_word({2'b10, low});
      check("wr_busy_arg", 32'(ifc.busy), 32'(1));
      check("wr_noreq_arg", 32'(ifc.bus_req), 32'(0));
      send_word(wdata);
    end else begin
      send_word({2'b11, low});
    end
    check("xfer_req_start", 32'(ifc.bus_req), 32'(1));
    check("xfer_we",        32'(ifc.bus_we),  32'(is_write));
    check("xfer_addr",      ifc.bus_addr,     addr_exp);
    if (is_write) check("xfer_wdata", ifc.bus_wdata, wdata);

    ncyc = (d < TO) ? d + 1 : TO;
    for (int i = 0; i < ncyc; i++) begin
      if (i == ncyc - 1) begin
        check("xfer_req_hold",   32'(ifc.bus_req), 32'(1));
        check("xfer_addr_hold",  ifc.bus_addr,     addr_exp);
        check("xfer_we_hold",    32'(ifc.bus_we),  32'(is_write));
        if (is_write) check("xfer_wdata_hold", ifc.bus_wdata, wdata);
      end
      ifc.bus_ack   = (i == d);
      ifc.bus_rdata = (i == d) ? rdata : $urandom();
      if (i == ovr_at) begin
        ifc.cmd_word  = $urandom();
        ifc.cmd_valid = 1'b1;
      end
      tick();
      ifc.bus_ack   = 1'b0;
      ifc.cmd_valid = 1'b0;
    end

    if (ovr_at >= 0) m_err = 1'b1;
    if (d < TO) begin
      if (!is_write) m_resp = rdata;
      m_addr = m_addr + 32'd4;
    end else begin
      m_err = 1'b1;
    end
    check_idle(is_write ? "wr_done" : "rd_done");
  endtask

  task automatic idle_ack();
    ifc.bus_ack   = 1'b1;
    ifc.bus_rdata = $urandom();
    tick();
    ifc.bus_ack   = 1'b0;
    check_idle("idle_ack");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  initial begin
    int sel;
    int d;
    int ov;
    logic [31:0] a;

    reset         = 1'b1;
    ifc.cmd_word  = '0;
    ifc.cmd_valid = 1'b0;
    ifc.bus_ack   = 1'b0;
    ifc.bus_rdata = '0;
    tick();
    tick();
    check_idle("reset");
    check("reset_we",    32'(ifc.bus_we), 32'(0));
    check("reset_wdata", ifc.bus_wdata,   32'(0));
    reset = 1'b0;
    tick();

    // SET_ADDR 0x1000 then READ acked after 3 cycles.
    set_addr(30'h0, 32'h0000_1000);
    run_xfer(1'b0, 30'h0, 32'h0, 3, 32'hDEAD_BEEF, -1);
    check("rd_resp_deadbeef", ifc.resp_data, 32'hDEAD_BEEF);
    check("rd_next_addr",     ifc.bus_addr,  32'h0000_1004);

    // WRITE at the top of the address space wraps to zero.
    set_addr(30'h0, 32'hFFFF_FFFC);
    run_xfer(1'b1, 30'h0, 32'h1234_5678, 2, 32'h0, -1);
    check("wr_addr_wrap", ifc.bus_addr, 32'h0000_0000);

    // READ never acked: timeout, err set, resp unchanged; CTRL clears err.
    run_xfer(1'b0, 30'h0, 32'h0, TO, 32'h0, -1);
    check("timeout_err", 32'(ifc.err), 32'(1));
    ctrl(30'h2);
    check("ctrl_err_clear", 32'(ifc.err), 32'(0));

    // Overrun during an outstanding READ, which still completes.
    run_xfer(1'b0, 30'h0, 32'h0, 5, 32'hA5A5_0001, 2);
    check("overrun_err", 32'(ifc.err), 32'(1));
    ctrl(30'h2);

    // Ack in the last cycle before timeout: ack wins, no error.
    run_xfer(1'b0, 30'h0, 32'h0, TO - 1, 32'h0BAD_F00D, -1);
    check("ack_at_timeout_noerr", 32'(ifc.err), 32'(0));
    idle_ack();

    for (int it = 0; it < 200; it++) begin
      sel = $urandom_range(0, 9);
      d   = $urandom_range(0, TO + 2);
      ov  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, (d < TO) ? d : TO - 1) : -1;
      case (sel)
        0, 1: ctrl(30'($urandom()));
        2, 3: begin
          a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC)) : $urandom();
          set_addr(30'($urandom()), a);
        end
        4, 5, 6: run_xfer(1'b0, 30'($urandom()), 32'h0, d, $urandom(), ov);
        7, 8:    run_xfer(1'b1, 30'($urandom()), $urandom(), d, 32'h0, ov);
        default: idle_ack();
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    // Halt, then reset pulsed mid-WRITE while the request is outstanding.
    ctrl(30'h1);
    check("halt_set", 32'(ifc.halt_req), 32'(1));
    set_addr(30'h0, 32'h0000_2000);
    send_word(32'h8000_0000);
    send_word(32'hCAFE_0001);
    check("midrst_req_before", 32'(ifc.bus_req), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    m_addr = '0;
    m_resp = '0;
    m_err  = 1'b0;
    m_halt = 1'b0;
    check_idle("midrst_async");
    tick();
    tick();
    check_idle("midrst_held");
    check("midrst_wdata", ifc.bus_wdata, 32'(0));
    reset = 1'b0;
    run_xfer(1'b0, 30'h0, 32'h0, 1, 32'h5555_AAAA, -1);
    check("post_reset_addr", ifc.bus_addr, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_cmd_engine.md
DEBUG_CMD_ENGINE -- requirements
Module: debug_cmd_engine

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of clk cycles that bus_req waits for bus_ack.
REQ-002 clk  in  1  system clock; all logic is in this domain.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 cmd_word  in  32  command/argument word from the JTAG data register; stable whenever cmd_valid pulses.
REQ-005 cmd_valid  in  1  single-cycle pulse: cmd_word holds a new word.
REQ-006 resp_data  out  32  response word, fed back to the JTAG capture input.
REQ-007 bus_req  out  1  bus request; held until bus_ack or timeout.
REQ-008 bus_we  out  1  1 = write, 0 = read; valid while bus_req=1.
REQ-009 bus_addr  out  32  bus address.
REQ-010 bus_wdata  out  32  write data.
REQ-011 bus_ack  in  1  single-cycle completion; sampled only while bus_req=1.
REQ-012 bus_rdata  in  32  read data; valid in the bus_ack cycle.
REQ-013 halt_req  out  1  core halt request level.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err  out  1  sticky error flag.

Function
REQ-016 Command word: op = cmd_word[31:30]; 00 CTRL, 01 SET_ADDR, 10 WRITE, 11 READ.
REQ-017 CTRL executes in the cycle after cmd_valid, as follows.
- halt_req <= cmd_word[0].
- If cmd_word[1]=1, err clears.
- CTRL causes no bus activity.
REQ-018 SET_ADDR and WRITE: the FSM moves IDLE->ARG; the next cmd_valid supplies the argument.
- SET_ADDR: the argument loads the address register; the FSM returns to IDLE.
- WRITE: the argument loads bus_wdata; the FSM moves to REQ with bus_we=1.
REQ-019 READ: the FSM moves IDLE->REQ with bus_we=0; there is no argument word.
REQ-020 States are IDLE, ARG and REQ only. busy = (state != IDLE).
REQ-021 Request timing and completion.
- bus_req asserts in the first cycle of REQ and stays asserted, with bus_addr, bus_we and bus_wdata stable, until the cycle bus_ack=1.
- bus_req deasserts in the cycle after bus_ack.
- The FSM returns to IDLE.
REQ-022 On a READ bus_ack, resp_data <= bus_rdata. resp_data is otherwise unchanged by bus traffic.
REQ-023 After every acked WRITE or READ, the address register increments by 4, modulo 2^32: 0xFFFFFFFC wraps to 0x00000000.
REQ-024 Timeout counter behaviour.
- The counter clears on REQ entry and counts while bus_req=1.
- When the count reaches TIMEOUT_CYCLES without bus_ack: bus_req drops, err sets, the address does not increment, resp_data is unchanged, and the FSM returns to IDLE.
REQ-025 bus_ack and timeout in the same cycle: the ack wins; no error is flagged.
REQ-026 cmd_valid while in REQ: the word is discarded and err sets (overrun). The in-flight transaction completes normally.
REQ-027 cmd_valid while in ARG is always taken as the argument, whatever its op bits.
REQ-028 bus_ack while bus_req=0 is ignored.
REQ-029 Latency from the READ cmd_valid to bus_req is 1 cycle. Latency from bus_ack to updated resp_data is 1 cycle.

Reset
REQ-030 When reset asserts, the block asynchronously forces the following, regardless of state or any mid-transaction bus_req.
- state = IDLE.
- bus_req = 0, bus_we = 0.
- bus_addr = 0, bus_wdata = 0.
- resp_data = 0.
- halt_req = 0, err = 0, busy = 0.
- Timeout counter = 0.
REQ-031 No output toggles while reset is high. Operation resumes on the first clk edge after reset deasserts.

Verification
REQ-032 SET_ADDR 0x4000_0000 (word 0x4000_0000, then 0x0000_1000), then READ 0xC000_0000 with bus_ack and bus_rdata=0xDEADBEEF after 3 cycles -> bus_addr=0x1000, bus_we=0, resp_data=0xDEADBEEF, next address 0x1004.
REQ-033 SET_ADDR 0xFFFF_FFFC, then WRITE 0x8000_0000 with argument 0x1234_5678, acked -> bus_we=1, bus_wdata=0x12345678 at 0xFFFFFFFC, address wraps to 0x00000000.
REQ-034 READ with bus_ack never asserted -> bus_req high for exactly TIMEOUT_CYCLES cycles, then low; err=1; resp_data unchanged. A following CTRL 0x0000_0002 -> err=0.
REQ-035 cmd_valid during an outstanding READ -> word dropped, err=1, the READ completes on a later bus_ack, busy returns to 0.
REQ-036 CTRL 0x0000_0001 -> halt_req=1. Then reset pulsed mid-WRITE while bus_req=1 -> bus_req, halt_req and busy go 0 immediately; resp_data=0.
